// File: rtl/r_arbiter.sv
// R-channel arbiter: grants one of three slaves for a whole burst and muxes its beats.
// Define R_ARB_RR_EN for round-robin selection; otherwise fixed priority S0 > S1 > S2.
module r_arbiter #(
   parameter int ID_W   = 8,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ID_W-1:0]   RID_S0,
   input  logic [ID_W-1:0]   RID_S1,
   input  logic [ID_W-1:0]   RID_S2,
   input  logic [DATA_W-1:0] RDATA_S0,
   input  logic [DATA_W-1:0] RDATA_S1,
   input  logic [DATA_W-1:0] RDATA_S2,
   input  logic [1:0]        RRESP_S0,
   input  logic [1:0]        RRESP_S1,
   input  logic [1:0]        RRESP_S2,
   input  logic              RLAST_S0,
   input  logic              RLAST_S1,
   input  logic              RLAST_S2,
   input  logic              RVALID_S0,
   input  logic              RVALID_S1,
   input  logic              RVALID_S2,
   input  logic              RREADY,
   output logic [1:0]        SlaveID,
   output logic [ID_W-1:0]   RID,
   output logic [DATA_W-1:0] RDATA,
   output logic [1:0]        RRESP,
   output logic              RLAST,
   output logic              RVALID,
   output logic [CNT_W-1:0]  BEAT_CNT,
   output logic              BURST_ERR
);

   typedef enum logic {IDLE, GRANT} state_e;

   state_e            state_q;
   logic [1:0]        grant_q;
   logic [1:0]        grant_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        req;
   logic              hs;

   // First requester found scanning ptr, ptr+1, ptr+2 (mod 3); 3 when nobody requests.
   function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] ptr);
      logic [1:0] idx;
      logic [1:0] res;
      res = 2'd3;
      idx = ptr;
      for (int k = 0; k < 3; k++) begin
         if (res == 2'd3 && r[idx]) res = idx;
         idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end
      return res;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign req = {RVALID_S2, RVALID_S1, RVALID_S0};

`ifdef R_ARB_RR_EN
   logic [1:0] rr_ptr_q;
   assign grant_d = pick(req, rr_ptr_q);
`else
   assign grant_d = pick(req, 2'd0);
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         grant_q  <= 2'd0;
         cnt_q    <= '0;
`ifdef R_ARB_RR_EN
         rr_ptr_q <= 2'd0;
`endif
      end else if (state_q == IDLE) begin
         if (|req) begin
            state_q <= GRANT;
            grant_q <= grant_d;
            cnt_q   <= '0;
         end
      end else if (hs) begin
         cnt_q <= sat_inc(cnt_q);
         if (RLAST) begin
            state_q  <= IDLE;
`ifdef R_ARB_RR_EN
            rr_ptr_q <= (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
`endif
         end
      end
   end

   // Beat fields follow the granted slave combinationally; all zero while idle.
   always_comb begin
      RID    = '0;
      RDATA  = '0;
      RRESP  = 2'd0;
      RLAST  = 1'b0;
      RVALID = 1'b0;
      if (state_q == GRANT) begin
         case (grant_q)
            2'd0: begin
               RID = RID_S0; RDATA = RDATA_S0; RRESP = RRESP_S0; RLAST = RLAST_S0; RVALID = RVALID_S0;
            end
            2'd1: begin
               RID = RID_S1; RDATA = RDATA_S1; RRESP = RRESP_S1; RLAST = RLAST_S1; RVALID = RVALID_S1;
            end
            2'd2: begin
               RID = RID_S2; RDATA = RDATA_S2; RRESP = RRESP_S2; RLAST = RLAST_S2; RVALID = RVALID_S2;
            end
            default: ;
         endcase
      end
   end

   assign SlaveID   = (state_q == GRANT) ? grant_q : 2'd3;
   assign hs        = RVALID && RREADY;
   assign BEAT_CNT  = cnt_q;
   assign BURST_ERR = hs && !RLAST && (cnt_q == CNT_W'(16));

endmodule
